vehicle_check_sequencer: RTL and testbench
==========================================

VEHICLE_CHECK_SEQUENCER -- requirements
Module: vehicle_check_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHECKS, default 6, number of ordered pre-start checks; legal range 1 to 2**CODE_W-2.
REQ-002 SHALL have parameter CODE_W, default 4, width of check codes and light.
REQ-003 SHALL have parameter DWELL_CYCLES, default 7, cycles the acknowledged light is held before the next check; minimum 1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000, cycles allowed per check; 0 disables the timeout.
REQ-005 SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit, in_code is presented this cycle.
REQ-008 SHALL have port in_code, input, CODE_W bits, sensor/check code (0 = NoUser, k = check k, NUM_CHECKS+1 = Start).
REQ-009 SHALL have port clear, input, 1 bit, synchronous abort/acknowledge returning to IDLE.
REQ-010 SHALL have port light, output, CODE_W bits, registered indicator code.
REQ-011 SHALL have port state, output, 3 bits, encoded as IDLE=0, CHECK=1, DWELL=2, READY=3, FAULT=4.
REQ-012 SHALL have port step, output, clog2(NUM_CHECKS+1) bits, number of checks passed.
REQ-013 SHALL have port flag, output, 1 bit, vehicle ready (sequence complete).
REQ-014 SHALL have port fault, output, 1 bit, sequence failed.
REQ-015 SHALL have port fault_code, output, 2 bits: 0 = none, 1 = wrong code, 2 = timeout.

Function
REQ-016 All outputs SHALL be registered and SHALL change only on the rising edge of clk, except on reset assertion.
REQ-017 clear SHALL have priority over in_valid in every state; when asserted, the next state SHALL be IDLE with light=0, step=0, flag=0, fault=0, fault_code=0.
REQ-018 In IDLE, in_valid with in_code==1 SHALL move to DWELL with light=1 and step=1; any other code SHALL leave the block in IDLE with no output change.
REQ-019 On entering DWELL, the dwell counter SHALL load DWELL_CYCLES-1 and decrement each cycle; the block SHALL remain in DWELL for exactly DWELL_CYCLES cycles, and in_valid SHALL be ignored throughout.
REQ-020 When DWELL ends with step==NUM_CHECKS, the next state SHALL be READY; otherwise it SHALL be CHECK.
REQ-021 On entering CHECK, the timeout counter SHALL clear, and it SHALL increment on each cycle without in_valid.
REQ-022 In CHECK, in_valid with in_code==step+1 SHALL move to DWELL with light=in_code and step=step+1.
REQ-023 In CHECK, in_valid with in_code!=step+1 SHALL move to FAULT with fault_code=1; light and step SHALL hold.
REQ-024 In CHECK with TIMEOUT_CYCLES>0, if in_valid is absent for TIMEOUT_CYCLES consecutive cycles, the block SHALL enter FAULT on the next edge with fault_code=2; light and step SHALL hold.
REQ-025 A valid input arriving in the same cycle the timeout expires SHALL take precedence over the timeout.
REQ-026 READY SHALL drive flag=1 and light=NUM_CHECKS+1, SHALL ignore in_valid, and SHALL be left only via clear or reset.
REQ-027 FAULT SHALL drive fault=1, SHALL ignore in_valid, and SHALL be left only via clear or reset.
REQ-028 flag and fault SHALL never be asserted simultaneously.
REQ-029 An unused state encoding SHALL transition to IDLE on the next edge, with all outputs set to their reset values.

Reset
REQ-030 Asserting rst_n low SHALL immediately force state=IDLE, light=0, step=0, flag=0, fault=0, fault_code=0, and clear both internal counters, independent of clk.
REQ-031 After rst_n deasserts, the block SHALL accept in_code==1 on the first rising edge of clk.

Verification (default parameters)
REQ-032 Happy path: codes 1..6 presented one per CHECK visit -> light steps 1..6, each held 7 cycles; then state=3, flag=1, light=7, step=6.
REQ-033 Wrong code: pass codes 1 and 2, then present 4 -> state=4, fault=1, fault_code=1, step=2, light=2.
REQ-034 Timeout: pass code 1, then hold in_valid low -> FAULT with fault_code=2 exactly 1000 cycles after entering CHECK; in_valid on cycle 1000 instead -> DWELL.
REQ-035 Dwell immunity: assert in_valid with code 2 on every DWELL cycle after code 1 -> step stays 1 for 7 cycles, with no fault.
REQ-036 Reset mid-DWELL at step 3 -> all outputs zero immediately; a subsequent code 1 -> DWELL with light=1.
REQ-037 clear and in_valid(code 3) together in CHECK at step 2 -> IDLE, step=0; clear in READY -> flag=0, light=0.

Source files
------------

// File: rtl/vehicle_check_sequencer.sv
// -----------------------------------------------------------------------------
// vehicle_check_sequencer
//
// Walks an operator through an ordered list of pre-start checks. Each check
// code must arrive in order (1, 2, ... NUM_CHECKS). After every accepted code
// the matching indicator is held for DWELL_CYCLES cycles before the next check
// is accepted. Once the last check has dwelt, the block reports READY and
// shows the Start code. A wrong code or a stalled check (TIMEOUT_CYCLES without
// any input) latches FAULT. Only clear or reset leaves READY and FAULT.
//
// Ports
//   clk         : single clock, rising edge active
//   rst_n       : asynchronous active-low reset
//   in_valid    : in_code is presented this cycle
//   in_code     : check code (0 = NoUser, k = check k, NUM_CHECKS+1 = Start)
//   clear       : synchronous abort/acknowledge, back to IDLE (top priority)
//   light       : registered indicator code
//   state       : IDLE=0, CHECK=1, DWELL=2, READY=3, FAULT=4
//   step        : number of checks passed
//   flag        : vehicle ready
//   fault       : sequence failed
//   fault_code  : 0 = none, 1 = wrong code, 2 = timeout
// -----------------------------------------------------------------------------
module vehicle_check_sequencer #(
    parameter int NUM_CHECKS     = 6,
    parameter int CODE_W         = 4,
    parameter int DWELL_CYCLES   = 7,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [CODE_W-1:0]               in_code,
    input  logic                            clear,
    output logic [CODE_W-1:0]               light,
    output logic [2:0]                      state,
    output logic [$clog2(NUM_CHECKS+1)-1:0] step,
    output logic                            flag,
    output logic                            fault,
    output logic [1:0]                      fault_code
);

    localparam int STEP_W = $clog2(NUM_CHECKS + 1);
    localparam int DW_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DW_W-1:0]   DW_LOAD    = DW_W'(DWELL_CYCLES - 1);
    // Counter value during the last permitted idle cycle of a check.
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(NUM_CHECKS);
    localparam logic [CODE_W-1:0] CODE_FIRST = CODE_W'(1);
    localparam logic [CODE_W-1:0] CODE_START = CODE_W'(NUM_CHECKS + 1);

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_WRONG   = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_DWELL = 3'd2,
        S_READY = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    state_e              r_state,       w_state;
    logic [CODE_W-1:0]   r_light,       w_light;
    logic [STEP_W-1:0]   r_step,        w_step;
    logic                r_flag,        w_flag;
    logic                r_fault,       w_fault;
    logic [1:0]          r_fault_code,  w_fault_code;
    logic [DW_W-1:0]     r_dwell_cnt,   w_dwell_cnt;
    logic [TO_W-1:0]     r_timeout_cnt, w_timeout_cnt;

    logic [CODE_W-1:0]   w_next_code;
    logic                w_timeout_hit;

    // Code the current check is waiting for; step < NUM_CHECKS in CHECK, so it fits.
    assign w_next_code   = CODE_W'(r_step) + CODE_W'(1);
    assign w_timeout_hit = (TIMEOUT_CYCLES > 0) && (r_timeout_cnt == TO_LAST);

    // NOTE: every next-state variable is given its hold value first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state       = r_state;
        w_light       = r_light;
        w_step        = r_step;
        w_flag        = r_flag;
        w_fault       = r_fault;
        w_fault_code  = r_fault_code;
        w_dwell_cnt   = r_dwell_cnt;
        w_timeout_cnt = r_timeout_cnt;

        if (clear) begin
            w_state       = S_IDLE;
            w_light       = '0;
            w_step        = '0;
            w_flag        = 1'b0;
            w_fault       = 1'b0;
            w_fault_code  = FC_NONE;
            w_dwell_cnt   = '0;
            w_timeout_cnt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && (in_code == CODE_FIRST)) begin
                        w_state     = S_DWELL;
                        w_light     = CODE_FIRST;
                        w_step      = STEP_W'(1);
                        w_dwell_cnt = DW_LOAD;
                    end
                end

                S_DWELL: begin
                    // in_valid is deliberately not looked at while dwelling.
                    if (r_dwell_cnt == '0) begin
                        if (r_step == STEP_LAST) begin
                            w_state = S_READY;
                            w_light = CODE_START;
                            w_flag  = 1'b1;
                        end else begin
                            w_state       = S_CHECK;
                            w_timeout_cnt = '0;
                        end
                    end else begin
                        w_dwell_cnt = r_dwell_cnt - DW_W'(1);
                    end
                end

                S_CHECK: begin
                    // A code arriving on the expiry cycle beats the timeout.
                    if (in_valid) begin
                        if (in_code == w_next_code) begin
                            w_state     = S_DWELL;
                            w_light     = in_code;
                            w_step      = r_step + STEP_W'(1);
                            w_dwell_cnt = DW_LOAD;
                        end else begin
                            w_state      = S_FAULT;
                            w_fault      = 1'b1;
                            w_fault_code = FC_WRONG;
                        end
                    end else if (w_timeout_hit) begin
                        w_state      = S_FAULT;
                        w_fault      = 1'b1;
                        w_fault_code = FC_TIMEOUT;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        w_timeout_cnt = r_timeout_cnt + TO_W'(1);
                    end
                end

                S_READY, S_FAULT: begin
                    // Terminal until clear or reset.
                end

                default: begin
                    w_state       = S_IDLE;
                    w_light       = '0;
                    w_step        = '0;
                    w_flag        = 1'b0;
                    w_fault       = 1'b0;
                    w_fault_code  = FC_NONE;
                    w_dwell_cnt   = '0;
                    w_timeout_cnt = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_light       <= '0;
            r_step        <= '0;
            r_flag        <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= FC_NONE;
            r_dwell_cnt   <= '0;
            r_timeout_cnt <= '0;
        end else begin
            r_state       <= w_state;
            r_light       <= w_light;
            r_step        <= w_step;
            r_flag        <= w_flag;
            r_fault       <= w_fault;
            r_fault_code  <= w_fault_code;
            r_dwell_cnt   <= w_dwell_cnt;
            r_timeout_cnt <= w_timeout_cnt;
        end
    end

    assign light      = r_light;
    assign state      = r_state;
    assign step       = r_step;
    assign flag       = r_flag;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule

// File: tb/tb_vehicle_check_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vehicle_check_sequencer
//
// Directed bench for vehicle_check_sequencer at default parameters
// (6 checks, 4-bit codes, 7-cycle dwell, 1000-cycle timeout). Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vehicle_check_sequencer;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_DWELL = 3'd2;
    localparam logic [2:0] ST_READY = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_code;
    logic       clear;
    logic [3:0] light;
    logic [2:0] state;
    logic [2:0] step;
    logic       flag;
    logic       fault;
    logic [1:0] fault_code;

    int n_vec  = 0;
    int n_miss = 0;

    vehicle_check_sequencer #(
        .NUM_CHECKS     (6),
        .CODE_W         (4),
        .DWELL_CYCLES   (7),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .clear      (clear),
        .light      (light),
        .state      (state),
        .step       (step),
        .flag       (flag),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] s, input logic [3:0] l,
                             input logic [2:0] st, input logic fl, input logic fa,
                             input logic [1:0] fc);
        check({tag, ".state"},      32'(state),      32'(s));
        check({tag, ".light"},      32'(light),      32'(l));
        check({tag, ".step"},       32'(step),       32'(st));
        check({tag, ".flag"},       32'(flag),       32'(fl));
        check({tag, ".fault"},      32'(fault),      32'(fa));
        check({tag, ".fault_code"}, 32'(fault_code), 32'(fc));
    endtask

    // Present one code for one clock edge; returns at the following falling edge.
    task automatic send(input logic [3:0] code);
        in_valid = 1'b1;
        in_code  = code;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Accept check k, confirm it dwells exactly 7 cycles, then lands in CHECK
    // (or READY after the sixth check).
    task automatic pass_check(input int k);
        send(4'(k));
        check_all($sformatf("accept%0d", k), ST_DWELL, 4'(k), 3'(k), 1'b0, 1'b0, 2'd0);
        repeat (6) @(negedge clk);
        check($sformatf("dwell7_%0d.state", k), 32'(state), 32'(ST_DWELL));
        @(negedge clk);
        check($sformatf("after_dwell%0d.state", k), 32'(state),
              (k == 6) ? 32'(ST_READY) : 32'(ST_CHECK));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = 4'd0;
        clear    = 1'b0;

        // Reset state, before any clock edge.
        #3;
        check_all("reset", ST_IDLE, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0);

        // Code 1 accepted on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        send(4'd1);
        check_all("first_edge", ST_DWELL, 4'd1, 3'd1, 1'b0, 1'b0, 2'd0);
        do_clear();
        check_all("clear_dwell", ST_IDLE, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0);

        // IDLE ignores codes other than 1.
        send(4'd2);
        check_all("idle_ignore", ST_IDLE, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0);

        // Happy path through all six checks.
        for (int k = 1; k <= 6; k++) pass_check(k);
        check_all("ready", ST_READY, 4'd7, 3'd6, 1'b1, 1'b0, 2'd0);
        send(4'd1);
        check_all("ready_hold", ST_READY, 4'd7, 3'd6, 1'b1, 1'b0, 2'd0);
        do_clear();
        check_all("clear_ready", ST_IDLE, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0);

        // Dwell immunity: code 2 held valid for the whole dwell.
        send(4'd1);
        in_valid = 1'b1;
        in_code  = 4'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("immune%0d.state", i), 32'(state), 32'(ST_DWELL));
            check($sformatf("immune%0d.step", i),  32'(step),  32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_all("immune_end", ST_CHECK, 4'd1, 3'd1, 1'b0, 1'b0, 2'd0);

        // Wrong code after checks 1 and 2.
        pass_check(2);
        send(4'd4);
        check_all("wrong_code", ST_FAULT, 4'd2, 3'd2, 1'b0, 1'b1, 2'd1);
        send(4'd3);
        check_all("fault_hold", ST_FAULT, 4'd2, 3'd2, 1'b0, 1'b1, 2'd1);
        do_clear();
        check_all("clear_fault", ST_IDLE, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0);

        // clear beats in_valid in CHECK at step 2.
        pass_check(1);
        pass_check(2);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_code  = 4'd3;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check_all("clear_prio", ST_IDLE, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0);

        // Timeout exactly 1000 cycles after entering CHECK.
        pass_check(1);
        repeat (999) @(negedge clk);
        check("timeout_999.state", 32'(state), 32'(ST_CHECK));
        @(negedge clk);
        check_all("timeout", ST_FAULT, 4'd1, 3'd1, 1'b0, 1'b1, 2'd2);
        do_clear();

        // Valid code on cycle 1000 wins over the timeout.
        pass_check(1);
        repeat (999) @(negedge clk);
        send(4'd2);
        check_all("timeout_race", ST_DWELL, 4'd2, 3'd2, 1'b0, 1'b0, 2'd0);
        do_clear();

        // Asynchronous reset in the middle of the step-3 dwell.
        pass_check(1);
        pass_check(2);
        send(4'd3);
        check_all("pre_reset", ST_DWELL, 4'd3, 3'd3, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", ST_IDLE, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(4'd1);
        check_all("after_reset", ST_DWELL, 4'd1, 3'd1, 1'b0, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
